alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the CPU's combinational 32-bit ALU.
- Supports the single-cycle arithmetic/logic/shift set at any WIDTH, with a registered result.
- Adds iterative signed multiply and divide.
- Sits between decode/regfile-read and the writeback stage.
- The processor stalls on in_ready/out_valid instead of using external multdiv control.
- Checkers-specific sur/sul/sura/sula ops stay outside this block.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width; localparam, derived from WIDTH.
- CNTW, $clog2(WIDTH+1), iteration counter width; localparam.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request can be accepted this cycle.
- ctrl_ALUopcode  in  5  operation select.
- ctrl_shiftamt  in  SHW  shift amount for sll/sra.
- data_operandA  in  WIDTH  operand A.
- data_operandB  in  WIDTH  operand B.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes result.
- data_result  out  WIDTH  result.
- isNotEqual  out  1  A != B; meaningful for sub only, 0 otherwise.
- isLessThan  out  1  signed A < B; sub only, 0 otherwise.
- overflow  out  1  signed overflow (add/sub/mul/div).
- div_by_zero  out  1  div with B == 0.

Behaviour:
- Opcodes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 01000 not(A), 00110 mul, 00111 div.
- Any other opcode: result 0, all flags 0, single-cycle timing.
- Reset (asynchronous, active-high):
  - state = IDLE, out_valid = 0.
  - data_result and all flags = 0; counter and accumulators cleared.
  - A reset during ITER/FIX aborts the operation; no result is ever emitted for it.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept occurs on a rising edge with in_valid && in_ready; operands and opcode are captured then.
- Single-cycle ops: result and flags are registered at the accept edge, so out_valid = 1 in the next cycle (latency 1).
- Back-to-back single-cycle ops sustain 1 op/cycle when out_ready = 1.
- Output hold: while out_valid && !out_ready, data_result and flags are stable. When out_valid && out_ready with no new accept, out_valid drops to 0 the next cycle.
- add/sub:
  - Wrap modulo 2^WIDTH.
  - overflow = operands' signs agree (B inverted for sub) and result sign differs.
  - For sub: isLessThan = result_sign XOR overflow; isNotEqual = |result.
- sll/sra: shift A by ctrl_shiftamt; sra replicates the sign bit.
- mul/div FSM, IDLE -> ITER -> FIX -> IDLE:
  - At the accept edge, register sign and magnitude of both operands, set counter = WIDTH, and clear out_valid if it was being consumed.
  - ITER: one radix-2 step per cycle.
    - mul: shift-add into a 2*WIDTH accumulator.
    - div: restoring step on remainder/quotient.
    - Counter decrements; leave ITER when the counter reaches 0.
  - FIX: apply sign (negate if signs differ; remainder is discarded), compute flags, set out_valid, return to IDLE.
  - out_valid rises WIDTH+2 cycles after the accept edge. in_ready = 0 throughout.
- mul:
  - Result = low WIDTH bits of the signed product.
  - overflow = 1 iff the full signed product ≠ sign-extension of the low WIDTH bits.
- div:
  - Signed, truncates toward zero.
  - B == 0: result 0, div_by_zero = 1, overflow = 0; still takes full latency.
  - A = MIN, B = −1: result MIN, overflow = 1.
- Flags not defined for an op are 0.

Decomposition:
- Package alu_seq_pkg:
  - Opcode localparams (OP_ADD … OP_DIV).
  - FSM state encoding (IDLE, ITER, FIX).
- One sub-module: alu_seq_iter, the mul/div datapath (magnitudes, accumulator, counter, sign fix).
  - Handshake is start/done with the parent FSM.
- Single-cycle ops are inline in alu_seq.

Test Plan:
1. WIDTH=32, add 0x7FFFFFFF+1, out_ready=1 -> next cycle out_valid=1, result 0x80000000, overflow=1. Then sub 5−7 on the following cycle -> result 0xFFFFFFFE, isLessThan=1, isNotEqual=1, overflow=0.
2. WIDTH=32, mul −3×7 accepted at cycle 0 -> in_ready=0 for cycles 1–33, out_valid at cycle 34, result 0xFFFFFFEB (−21), overflow=0. Also mul 0x10000×0x10000 -> result 0, overflow=1.
3. WIDTH=8 div cases:
   - −7/2 -> result 0xFD (−3).
   - 0x80/0xFF -> result 0x80, overflow=1.
   - 5/0 -> result 0, div_by_zero=1.
   - Each with out_valid 10 cycles after accept.
4. Backpressure: sra 0x80000000 by 4 with out_ready=0 for 5 cycles -> result 0xF8000000 held stable, in_ready=0. Raising out_ready with in_valid set accepts the next op in the same cycle.
5. Reset asserted asynchronously mid-div (cycle 10 of ITER) -> out_valid, data_result and flags = 0 immediately; after release, in_ready=1 and no stale result ever appears.
6. Unknown opcode 01111 -> result 0, all flags 0, latency 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
// Imported by the top and by the mul/div datapath.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative signed multiply / restoring divide on operand magnitudes.
// Loads on start_i, steps once per cycle until the counter is zero; sign fix is combinational.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             div_by_zero_o
);

    localparam int CNTW = $clog2(WIDTH + 1);

    logic                 is_div_q, neg_q, bzero_q;
    logic [WIDTH-1:0]     b_mag_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]      cnt_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial, div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo, quo_s;

    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);

    // Divide: acc = {remainder, dividend/quotient}; shift left and try subtracting.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, b_mag_q};
    assign div_rem   = div_ge ? (div_trial - {1'b0, b_mag_q}) : div_trial;

    always_comb begin
        acc_d = acc_q;
        if (cnt_q != '0) begin
            if (is_div_q) begin
                acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            is_div_q <= is_div_i;
            neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            bzero_q  <= (b_i == '0);
            b_mag_q  <= b_mag;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            cnt_q    <= CNTW'(WIDTH);
        end else begin
            acc_q <= acc_d;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNTW'(1);
            end
        end
    end

    assign done_o = (cnt_q == '0);
    assign prod_s = neg_q ? -acc_q : acc_q;
    assign quo    = acc_q[WIDTH-1:0];
    assign quo_s  = neg_q ? -quo : quo;

    // A positive quotient with the top bit set only arises from MIN / -1.
    always_comb begin
        result_o      = prod_s[WIDTH-1:0];
        overflow_o    = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
        div_by_zero_o = 1'b0;
        if (is_div_q) begin
            result_o      = bzero_q ? '0 : quo_s;
            overflow_o    = !bzero_q && !neg_q && quo[WIDTH-1];
            div_by_zero_o = bzero_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops registered at accept, mul/div via the iterative datapath.
// in_ready = IDLE && (!out_valid || out_ready); results hold while out_valid && !out_ready.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             div_by_zero
);

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [WIDTH-1:0] sum, diff, sc_result;
    logic             sc_ne, sc_lt, sc_ovf;
    logic             accept, is_iter_op, start;
    logic             iter_done, iter_ovf, iter_dbz;
    logic [WIDTH-1:0] iter_result;

    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_iter_op = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);
    assign sum        = data_operandA + data_operandB;
    assign diff       = data_operandA - data_operandB;

    always_comb begin
        sc_result = '0;
        sc_ne     = 1'b0;
        sc_lt     = 1'b0;
        sc_ovf    = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                            (sum[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                            (diff[WIDTH-1] != data_operandA[WIDTH-1]);
                sc_lt     = diff[WIDTH-1] ^ sc_ovf;
                sc_ne     = |diff;
            end
            OP_AND:  sc_result = data_operandA & data_operandB;
            OP_OR:   sc_result = data_operandA | data_operandB;
            OP_SLL:  sc_result = data_operandA << ctrl_shiftamt;
            OP_SRA:  sc_result = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_NOT:  sc_result = ~data_operandA;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        start       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_iter_op) begin
                    start       = 1'b1;
                    state_d     = ST_ITER;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = sc_result;
                    ne_d        = sc_ne;
                    lt_d        = sc_lt;
                    ovf_d       = sc_ovf;
                    dbz_d       = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_ITER: begin
                if (iter_done) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                result_d    = iter_result;
                ne_d        = 1'b0;
                lt_d        = 1'b0;
                ovf_d       = iter_ovf;
                dbz_d       = iter_dbz;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ne_q        <= ne_d;
            lt_q        <= lt_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clock         (clock),
        .reset         (reset),
        .start_i       (start),
        .is_div_i      (ctrl_ALUopcode == OP_DIV),
        .a_i           (data_operandA),
        .b_i           (data_operandB),
        .done_o        (iter_done),
        .result_o      (iter_result),
        .overflow_o    (iter_ovf),
        .div_by_zero_o (iter_dbz)
    );

    assign out_valid   = out_valid_q;
    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance on a shared clock.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        rst32, iv32, ir32, ov32, or32, ne32, lt32, of32, dz32;
    logic [4:0]  op32;
    logic [4:0]  sh32;
    logic [31:0] a32, b32, res32;

    // 8-bit instance
    logic        rst8, iv8, ir8, ov8, or8, ne8, lt8, of8, dz8;
    logic [4:0]  op8;
    logic [2:0]  sh8;
    logic [7:0]  a8, b8, res8;

    alu_seq #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(rst32), .in_valid(iv32), .in_ready(ir32),
        .ctrl_ALUopcode(op32), .ctrl_shiftamt(sh32),
        .data_operandA(a32), .data_operandB(b32),
        .out_valid(ov32), .out_ready(or32), .data_result(res32),
        .isNotEqual(ne32), .isLessThan(lt32), .overflow(of32), .div_by_zero(dz32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
        .ctrl_ALUopcode(op8), .ctrl_shiftamt(sh8),
        .data_operandA(a8), .data_operandB(b8),
        .out_valid(ov8), .out_ready(or8), .data_result(res8),
        .isNotEqual(ne8), .isLessThan(lt8), .overflow(of8), .div_by_zero(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out32(output int lat, output bit saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        while (ov32 !== 1'b1 && lat < 200) begin
            if (ir32 !== 1'b0) saw_ready = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic wait_out8(output int lat, output bit saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        while (ov8 !== 1'b1 && lat < 200) begin
            if (ir8 !== 1'b0) saw_ready = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic issue32(input logic [4:0] op, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b);
        op32 = op; sh32 = sh; a32 = a; b32 = b; iv32 = 1'b1;
    endtask

    task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        op8 = op; sh8 = 3'd0; a8 = a; b8 = b; iv8 = 1'b1;
    endtask

    int lat;
    bit saw;
    bit bad;

    initial begin
        rst32 = 1'b1; rst8 = 1'b1;
        iv32 = 1'b0; op32 = '0; sh32 = '0; a32 = '0; b32 = '0; or32 = 1'b1;
        iv8 = 1'b0; op8 = '0; sh8 = '0; a8 = '0; b8 = '0; or8 = 1'b1;
        tick();
        tick();
        rst32 = 1'b0; rst8 = 1'b0;
        #1;
        chk("reset out_valid", ov32, 1'b0);
        chk("reset result", res32, 32'h0);
        chk("reset flags", {ne32, lt32, of32, dz32}, 4'b0000);
        chk("reset in_ready", ir32, 1'b1);

        // add overflow then sub back-to-back
        issue32(OP_ADD, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        chk("add valid", ov32, 1'b1);
        chk("add result", res32, 32'h8000_0000);
        chk("add flags", {ne32, lt32, of32, dz32}, 4'b0010);
        issue32(OP_SUB, 5'd0, 32'd5, 32'd7);
        tick();
        chk("sub valid", ov32, 1'b1);
        chk("sub result", res32, 32'hFFFF_FFFE);
        chk("sub flags", {ne32, lt32, of32, dz32}, 4'b1100);
        issue32(OP_SLL, 5'd31, 32'h0000_0001, 32'h0);
        tick();
        chk("sll result", res32, 32'h8000_0000);
        issue32(OP_NOT, 5'd0, 32'h0000_FFFF, 32'h1234_5678);
        tick();
        chk("not result", res32, 32'hFFFF_0000);
        issue32(5'b01111, 5'd3, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        iv32 = 1'b0;
        chk("unknown valid", ov32, 1'b1);
        chk("unknown result", res32, 32'h0);
        chk("unknown flags", {ne32, lt32, of32, dz32}, 4'b0000);
        tick();
        chk("drain valid", ov32, 1'b0);

        // mul -3 * 7
        issue32(OP_MUL, 5'd0, 32'hFFFF_FFFD, 32'd7);
        tick();
        iv32 = 1'b0;
        wait_out32(lat, saw);
        chk("mul latency", lat, 34);
        chk("mul in_ready low", saw, 1'b0);
        chk("mul result", res32, 32'hFFFF_FFEB);
        chk("mul flags", {ne32, lt32, of32, dz32}, 4'b0000);
        tick();
        issue32(OP_MUL, 5'd0, 32'h0001_0000, 32'h0001_0000);
        tick();
        iv32 = 1'b0;
        wait_out32(lat, saw);
        chk("mul big latency", lat, 34);
        chk("mul big result", res32, 32'h0);
        chk("mul big flags", {ne32, lt32, of32, dz32}, 4'b0010);
        tick();

        // 8-bit divides
        issue8(OP_DIV, 8'hF9, 8'h02);
        tick();
        iv8 = 1'b0;
        wait_out8(lat, saw);
        chk("div8 a latency", lat, 10);
        chk("div8 a in_ready low", saw, 1'b0);
        chk("div8 a result", res8, 8'hFD);
        chk("div8 a flags", {ne8, lt8, of8, dz8}, 4'b0000);
        tick();
        issue8(OP_DIV, 8'h80, 8'hFF);
        tick();
        iv8 = 1'b0;
        wait_out8(lat, saw);
        chk("div8 min latency", lat, 10);
        chk("div8 min result", res8, 8'h80);
        chk("div8 min flags", {ne8, lt8, of8, dz8}, 4'b0010);
        tick();
        issue8(OP_DIV, 8'h05, 8'h00);
        tick();
        iv8 = 1'b0;
        wait_out8(lat, saw);
        chk("div8 zero latency", lat, 10);
        chk("div8 zero result", res8, 8'h00);
        chk("div8 zero flags", {ne8, lt8, of8, dz8}, 4'b0001);
        tick();

        // backpressure on sra
        or32 = 1'b0;
        issue32(OP_SRA, 5'd4, 32'h8000_0000, 32'h0);
        tick();
        chk("sra valid", ov32, 1'b1);
        chk("sra result", res32, 32'hF800_0000);
        issue32(OP_AND, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (ov32 !== 1'b1 || res32 !== 32'hF800_0000 || ir32 !== 1'b0) bad = 1'b1;
        end
        chk("sra hold stable", bad, 1'b0);
        or32 = 1'b1;
        #1;
        chk("release in_ready", ir32, 1'b1);
        tick();
        iv32 = 1'b0;
        chk("and valid", ov32, 1'b1);
        chk("and result", res32, 32'hF000_F000);
        tick();
        chk("and drained", ov32, 1'b0);

        // reset in the middle of a divide
        issue32(OP_DIV, 5'd0, 32'd100, 32'd7);
        tick();
        iv32 = 1'b0;
        repeat (11) tick();
        chk("div busy in_ready", ir32, 1'b0);
        #2;
        rst32 = 1'b1;
        #1;
        chk("abort out_valid", ov32, 1'b0);
        chk("abort result", res32, 32'h0);
        chk("abort flags", {ne32, lt32, of32, dz32}, 4'b0000);
        tick();
        rst32 = 1'b0;
        #1;
        chk("post reset in_ready", ir32, 1'b1);
        bad = 1'b0;
        repeat (45) begin
            tick();
            if (ov32 !== 1'b0) bad = 1'b1;
        end
        chk("no stale result", bad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
